inst_fetch_stage: RTL and testbench

//  PC generator and IF/ID pipeline register directly upstream of the instruction ROM.

---
 rtl/inst_fetch_stage.sv | 136 +++++++++++++
 tb/tb_inst_fetch_stage.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch_stage.sv
// PC generator and IF/ID pipeline register in front of the instruction ROM.
// Optional out-of-range fetch fault detection is compiled in with `define FETCH_FAULT_EN.
module inst_fetch_stage #(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int          ROM_ADDR_W = 12,
   parameter int          ROM_WORDS  = 128
) (
   input  logic                  clk,
   input  logic                  reset,
   output logic [ROM_ADDR_W-1:0] rom_addr,
   input  logic [31:0]           rom_inst,
   input  logic                  stall,
   input  logic                  flush,
   input  logic                  redirect_valid,
   input  logic [31:0]           redirect_pc,
   output logic                  if_valid,
   output logic [31:0]           if_pc,
   output logic [31:0]           if_pc_plus4,
   output logic [31:0]           if_inst
`ifdef FETCH_FAULT_EN
   ,
   output logic                  fetch_fault
`endif
);

   localparam logic [31:0] NOP = 32'h0000_0013;

   logic [31:0] pc_q, pc_d;
   logic        if_valid_q, if_valid_d;
   logic [31:0] if_pc_q, if_pc_d;
   logic [31:0] if_pc_plus4_q, if_pc_plus4_d;
   logic [31:0] if_inst_q, if_inst_d;
   logic [31:0] pc_plus4_s;
   logic        oor_s;
   logic        halt_s;

   assign pc_plus4_s = pc_q + 32'd4;

`ifdef FETCH_FAULT_EN
   localparam logic [31:0] ROM_BYTES = 32'(ROM_WORDS * 4);

   logic fault_q, fault_d;

   assign oor_s       = (pc_q >= ROM_BYTES);
   assign halt_s      = fault_q;
   assign fetch_fault = fault_q;

   // Fault flag: set by an out-of-range capture, cleared by redirect or flush.
   always_comb begin
      fault_d = fault_q;
      if (redirect_valid) begin
         fault_d = 1'b0;
      end else if (stall) begin
         fault_d = fault_q;
      end else if (flush) begin
         fault_d = 1'b0;
      end else if (!halt_s && oor_s) begin
         fault_d = 1'b1;
      end else begin
         fault_d = fault_q;
      end
   end

   // Fault flag register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         fault_q <= 1'b0;
      end else begin
         fault_q <= fault_d;
      end
   end
`else
   assign oor_s  = 1'b0;
   assign halt_s = 1'b0;
`endif

   // Next PC and IF/ID contents; redirect outranks stall, stall outranks flush.
   always_comb begin
      pc_d          = pc_q;
      if_valid_d    = if_valid_q;
      if_pc_d       = if_pc_q;
      if_pc_plus4_d = if_pc_plus4_q;
      if_inst_d     = if_inst_q;
      if (redirect_valid) begin
         pc_d       = redirect_pc & 32'hFFFF_FFFC;
         if_valid_d = 1'b0;
      end else if (stall) begin
         pc_d = pc_q;
      end else if (flush) begin
         if (halt_s) begin
            pc_d = pc_q;
         end else begin
            pc_d = pc_plus4_s;
         end
         if_valid_d = 1'b0;
      end else if (halt_s) begin
         // fetch is halted on a fault: no new instruction until redirected
         if_valid_d = 1'b0;
      end else begin
         if_pc_d       = pc_q;
         if_pc_plus4_d = pc_plus4_s;
         if_valid_d    = 1'b1;
         if (oor_s) begin
            if_inst_d = NOP;
            pc_d      = pc_q;
         end else begin
            if_inst_d = rom_inst;
            pc_d      = pc_plus4_s;
         end
      end
   end

   // PC and IF/ID pipeline registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pc_q          <= RESET_PC;
         if_valid_q    <= 1'b0;
         if_pc_q       <= 32'h0000_0000;
         if_pc_plus4_q <= 32'h0000_0004;
         if_inst_q     <= NOP;
      end else begin
         pc_q          <= pc_d;
         if_valid_q    <= if_valid_d;
         if_pc_q       <= if_pc_d;
         if_pc_plus4_q <= if_pc_plus4_d;
         if_inst_q     <= if_inst_d;
      end
   end

   assign rom_addr    = pc_q[ROM_ADDR_W-1:0];
   assign if_valid    = if_valid_q;
   assign if_pc       = if_pc_q;
   assign if_pc_plus4 = if_pc_plus4_q;
   assign if_inst     = if_inst_q;

endmodule

// File: tb/tb_inst_fetch_stage.sv
// Scoreboard bench for inst_fetch_stage: a reference model predicts each capture,
// the expected PC/instruction is queued and compared when the DUT presents it.
module tb_inst_fetch_stage;

   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk;
   logic        reset;
   logic [11:0] rom_addr;
   logic [31:0] rom_inst;
   logic        stall;
   logic        flush;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        if_valid;
   logic [31:0] if_pc;
   logic [31:0] if_pc_plus4;
   logic [31:0] if_inst;
`ifdef FETCH_FAULT_EN
   logic        fetch_fault;
`endif

   inst_fetch_stage dut (
      .clk            (clk),
      .reset          (reset),
      .rom_addr       (rom_addr),
      .rom_inst       (rom_inst),
      .stall          (stall),
      .flush          (flush),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .if_valid       (if_valid),
      .if_pc          (if_pc),
      .if_pc_plus4    (if_pc_plus4),
      .if_inst        (if_inst)
`ifdef FETCH_FAULT_EN
      ,
      .fetch_fault    (fetch_fault)
`endif
   );

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
   } exp_t;

   logic [31:0] rom [0:1023];
   exp_t        sb [$];

   int          checks = 0;
   int          errors = 0;

   logic [31:0] m_pc;
   logic        exp_valid;
   logic        m_fault;
   logic [31:0] last_pc;
   logic [31:0] last_p4;
   logic [31:0] last_inst;

   assign rom_inst = rom[rom_addr[11:2]];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] rom_val(input logic [31:0] a);
      return 32'h5A00_0000 ^ {a[11:2], 12'h000, a[11:2]};
   endfunction

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_pc      = 32'h0000_0000;
      exp_valid = 1'b0;
      m_fault   = 1'b0;
      last_pc   = 32'h0000_0000;
      last_p4   = 32'h0000_0004;
      last_inst = NOP;
      sb.delete();
   endtask

   task automatic check_reset_vals(input string tag);
      check_val({tag, "_valid"}, {31'h0, if_valid}, 32'd0);
      check_val({tag, "_pc"}, if_pc, 32'h0000_0000);
      check_val({tag, "_pc4"}, if_pc_plus4, 32'h0000_0004);
      check_val({tag, "_inst"}, if_inst, NOP);
      check_val({tag, "_addr"}, {20'h0, rom_addr}, 32'h0000_0000);
`ifdef FETCH_FAULT_EN
      check_val({tag, "_fault"}, {31'h0, fetch_fault}, 32'd0);
`endif
   endtask

   // One clock cycle: drive at negedge, predict, then compare at the next negedge.
   task automatic step(input logic st, input logic fl, input logic rv, input logic [31:0] rpc);
      logic normal;
      exp_t e;
      stall          = st;
      flush          = fl;
      redirect_valid = rv;
      redirect_pc    = rpc;
      check_val("rom_addr", {20'h0, rom_addr}, {20'h0, m_pc[11:0]});
      normal = 1'b0;
      if (rv) begin
         m_pc      = rpc & 32'hFFFF_FFFC;
         exp_valid = 1'b0;
         m_fault   = 1'b0;
      end else if (st) begin
         m_pc = m_pc;
      end else if (fl) begin
         if (!m_fault) m_pc = m_pc + 32'd4;
         m_fault   = 1'b0;
         exp_valid = 1'b0;
      end else begin
`ifdef FETCH_FAULT_EN
         if (m_fault) begin
            exp_valid = 1'b0;
         end else if (m_pc >= 32'h0000_0200) begin
            sb.push_back('{pc: m_pc, inst: NOP});
            exp_valid = 1'b1;
            m_fault   = 1'b1;
            normal    = 1'b1;
         end else begin
            sb.push_back('{pc: m_pc, inst: rom_val(m_pc)});
            exp_valid = 1'b1;
            normal    = 1'b1;
            m_pc      = m_pc + 32'd4;
         end
`else
         sb.push_back('{pc: m_pc, inst: rom_val(m_pc)});
         exp_valid = 1'b1;
         normal    = 1'b1;
         m_pc      = m_pc + 32'd4;
`endif
      end
      @(posedge clk);
      @(negedge clk);
      check_val("if_valid", {31'h0, if_valid}, {31'h0, exp_valid});
`ifdef FETCH_FAULT_EN
      check_val("fetch_fault", {31'h0, fetch_fault}, {31'h0, m_fault});
`endif
      if (normal) begin
         check_val("sb_size", 32'(sb.size()), 32'd1);
         if (sb.size() != 0) begin
            e         = sb.pop_front();
            last_pc   = e.pc;
            last_p4   = e.pc + 32'd4;
            last_inst = e.inst;
         end
      end
      check_val("if_pc", if_pc, last_pc);
      check_val("if_pc_plus4", if_pc_plus4, last_p4);
      check_val("if_inst", if_inst, last_inst);
   endtask

   initial begin
      for (int i = 0; i < 1024; i++) rom[i] = rom_val(32'(i * 4));
      reset          = 1'b1;
      stall          = 1'b0;
      flush          = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = 32'h0000_0000;
      model_reset();
      repeat (3) @(negedge clk);
      check_reset_vals("rst");
      reset = 1'b0;

      // straight-line fetch, then stall after the second capture
      step(1'b0, 1'b0, 1'b0, 32'h0);
      step(1'b0, 1'b0, 1'b0, 32'h0);
      step(1'b1, 1'b0, 1'b0, 32'h0);
      step(1'b1, 1'b0, 1'b0, 32'h0);
      step(1'b1, 1'b0, 1'b0, 32'h0);
      step(1'b0, 1'b0, 1'b0, 32'h0);
      step(1'b0, 1'b0, 1'b0, 32'h0);

      // redirect with unaligned target while stalled
      step(1'b1, 1'b0, 1'b1, 32'h0000_0041);
      step(1'b0, 1'b0, 1'b0, 32'h0);
      step(1'b0, 1'b0, 1'b0, 32'h0);

      // flush while pc = 0xC
      step(1'b0, 1'b0, 1'b1, 32'h0000_0000);
      step(1'b0, 1'b0, 1'b0, 32'h0);
      step(1'b0, 1'b0, 1'b0, 32'h0);
      step(1'b0, 1'b0, 1'b0, 32'h0);
      step(1'b0, 1'b1, 1'b0, 32'h0);
      step(1'b0, 1'b0, 1'b0, 32'h0);
      step(1'b0, 1'b0, 1'b0, 32'h0);

      // flush is ignored under stall
      step(1'b1, 1'b1, 1'b0, 32'h0);
      step(1'b0, 1'b0, 1'b0, 32'h0);

      // pc + 4 wrap and rom_addr aliasing
      step(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC);
      step(1'b0, 1'b0, 1'b0, 32'h0);
      step(1'b0, 1'b0, 1'b0, 32'h0);
      step(1'b0, 1'b0, 1'b1, 32'h0000_1006);
      step(1'b0, 1'b0, 1'b0, 32'h0);
      step(1'b0, 1'b0, 1'b0, 32'h0);

      // asynchronous reset while a redirect is being requested
      step(1'b0, 1'b0, 1'b1, 32'h0000_0100);
      step(1'b0, 1'b0, 1'b0, 32'h0);
      redirect_valid = 1'b1;
      redirect_pc    = 32'h0000_0080;
      #2 reset = 1'b1;
      #1 check_reset_vals("async_rst");
      @(negedge clk);
      check_reset_vals("rst_hold");
      reset          = 1'b0;
      redirect_valid = 1'b0;
      model_reset();
      step(1'b0, 1'b0, 1'b0, 32'h0);
      step(1'b0, 1'b0, 1'b0, 32'h0);

`ifdef FETCH_FAULT_EN
      // out-of-range fetch halts, redirect clears the fault and resumes
      step(1'b0, 1'b0, 1'b1, 32'h0000_0200);
      step(1'b0, 1'b0, 1'b0, 32'h0);
      check_val("fault_inst", if_inst, NOP);
      step(1'b0, 1'b0, 1'b0, 32'h0);
      step(1'b1, 1'b0, 1'b0, 32'h0);
      step(1'b0, 1'b0, 1'b0, 32'h0);
      step(1'b0, 1'b0, 1'b1, 32'h0000_0000);
      step(1'b0, 1'b0, 1'b0, 32'h0);
      step(1'b0, 1'b0, 1'b0, 32'h0);
`endif

      // random mix of stall, flush and redirect
      for (int n = 0; n < 400; n++) begin
         step($urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0,
              $urandom_range(0, 7) == 0, 32'($urandom_range(0, 1023)));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
